// File: rtl/tx_frame_sched.sv
// tx0 frame scheduler: picks the next frame (ARP ahead of test traffic),
// hands it to the generator, enforces the inter-frame gap and keeps the
// per-second test-frame packet/byte statistics.
module tx_frame_sched #(
  parameter int unsigned CLK_HZ  = 156250000,
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_enable,
  input  logic        req_arp,
  input  logic [15:0] frame_len,
  input  logic [31:0] inter_frame_gap,
  output logic        gen_req,
  output logic        gen_kind,
  output logic [15:0] gen_len,
  input  logic        gen_ack,
  input  logic        gen_done,
  output logic        arp_ack,
  output logic        busy,
  output logic [31:0] tx_pps,
  output logic [31:0] tx_throughput
);

  localparam logic [15:0] MIN_L   = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L   = 16'(MAX_LEN);
  localparam logic [31:0] WIN_END = 32'(CLK_HZ - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, GAP} state_t;

  typedef struct packed {
    logic        kind;
    logic [15:0] len;
  } frame_req_t;

  state_t      state, state_nxt;
  frame_req_t  req_q, req_nxt;
  logic        arp_q, arp_pend, arp_edge;
  logic        accept, arp_accept, test_accept;
  logic [32:0] gap_calc;
  logic [31:0] gap_calc_min1, gap_cycles, gap_left;
  logic [15:0] len_clamp;
  logic        load_req;
  logic [31:0] win_cnt, pkt_cnt, byte_cnt, pkt_nxt, byte_nxt;
  logic [32:0] byte_sum;
  logic        win_end;

  assign gen_kind    = req_q.kind;
  assign gen_len     = req_q.len;
  assign arp_edge    = req_arp & ~arp_q;
  assign accept      = gen_req & gen_ack;
  assign arp_accept  = accept & req_q.kind;
  assign test_accept = accept & ~req_q.kind;

  // Gap in 8-byte XGMII words, rounded up; 33 bits keeps 0xFFFFFFFF+7 exact.
  assign gap_calc      = ({1'b0, inter_frame_gap} + 33'd7) >> 3;
  assign gap_calc_min1 = (gap_calc == 33'd0) ? 32'd1 : gap_calc[31:0];
  assign len_clamp     = (frame_len < MIN_L) ? MIN_L :
                         (frame_len > MAX_L) ? MAX_L : frame_len;

  // Next-state decode; the frame descriptor only changes on an IDLE decision.
  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    load_req  = 1'b0;
    case (state)
      IDLE: begin
        if (arp_pend) begin
          state_nxt = REQ;
          req_nxt   = '{kind: 1'b1, len: MIN_L};
          load_req  = 1'b1;
        end else if (tx_enable) begin
          state_nxt = REQ;
          req_nxt   = '{kind: 1'b0, len: len_clamp};
          load_req  = 1'b1;
        end
      end
      REQ:  if (gen_ack) state_nxt = WAIT;
      WAIT: if (gen_done) state_nxt = GAP;
      GAP:  if (gap_left == 32'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, registered outputs and gap countdown.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_q      <= '0;
      gen_req    <= 1'b0;
      busy       <= 1'b0;
      arp_ack    <= 1'b0;
      gap_cycles <= 32'd1;
      gap_left   <= 32'd1;
    end else begin
      state   <= state_nxt;
      req_q   <= req_nxt;
      gen_req <= (state_nxt == REQ);
      busy    <= (state_nxt != IDLE);
      arp_ack <= arp_accept;
      if (load_req) gap_cycles <= gap_calc_min1;
      if (state == WAIT && gen_done) gap_left <= gap_cycles;
      else if (state == GAP)         gap_left <= gap_left - 32'd1;
    end
  end

  // ARP request edge detect; an edge coinciding with the accept re-arms.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arp_q    <= req_arp;
      arp_pend <= 1'b0;
    end else begin
      arp_q    <= req_arp;
      arp_pend <= arp_edge | (arp_pend & ~arp_accept);
    end
  end

  // Saturating per-window counts, including an accept on the current cycle.
  always_comb begin
    byte_sum = {1'b0, byte_cnt} + {17'd0, req_q.len};
    pkt_nxt  = pkt_cnt;
    byte_nxt = byte_cnt;
    if (test_accept) begin
      pkt_nxt  = (pkt_cnt == 32'hFFFF_FFFF) ? pkt_cnt : pkt_cnt + 32'd1;
      byte_nxt = byte_sum[32] ? 32'hFFFF_FFFF : byte_sum[31:0];
    end
  end

  assign win_end = (win_cnt == WIN_END);

  // Free-running window; the last cycle publishes and clears the counts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt       <= '0;
      pkt_cnt       <= '0;
      byte_cnt      <= '0;
      tx_pps        <= '0;
      tx_throughput <= '0;
    end else begin
      win_cnt <= win_end ? 32'd0 : win_cnt + 32'd1;
      if (win_end) begin
        tx_pps        <= pkt_nxt;
        tx_throughput <= byte_nxt;
        pkt_cnt       <= '0;
        byte_cnt      <= '0;
      end else begin
        pkt_cnt  <= pkt_nxt;
        byte_cnt <= byte_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_sched.sv
// Randomised scoreboard bench for tx_frame_sched: the driver queues the frame
// each stimulus should produce, a negedge monitor checks every request,
// gap length, arp_ack pulse and window statistic against a reference model.
module tb_tx_frame_sched;

  localparam int unsigned CLK_HZ = 1200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_enable = 1'b0;
  logic        req_arp = 1'b0;
  logic [15:0] frame_len = 16'd64;
  logic [31:0] inter_frame_gap = 32'd12;
  logic        gen_ack = 1'b0;
  logic        gen_done = 1'b0;
  logic        gen_req, gen_kind, arp_ack, busy;
  logic [15:0] gen_len;
  logic [31:0] tx_pps, tx_throughput;

  tx_frame_sched #(.CLK_HZ(CLK_HZ), .MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable), .req_arp(req_arp),
    .frame_len(frame_len), .inter_frame_gap(inter_frame_gap),
    .gen_req(gen_req), .gen_kind(gen_kind), .gen_len(gen_len),
    .gen_ack(gen_ack), .gen_done(gen_done), .arp_ack(arp_ack), .busy(busy),
    .tx_pps(tx_pps), .tx_throughput(tx_throughput)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit     kind;
    int     len;
    longint gap;   // 0 = too long to observe
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   ack_dly = 0;
  int   done_dly = 4;
  int   n_acc = 0;

  function automatic longint gap_of(longint ifg);
    longint words = (ifg + 7) / 8;
    return (words < 1) ? 1 : words;
  endfunction

  function automatic int clamp_len(int l);
    if (l < 64)   return 64;
    if (l > 1518) return 1518;
    return l;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Generator model: acks after ack_dly cycles, done done_dly cycles later.
  initial forever begin
    tick();
    if (rst_n && gen_req) begin
      repeat (ack_dly) tick();
      gen_ack = 1'b1; tick(); gen_ack = 1'b0;
      repeat (done_dly - 1) tick();
      gen_done = 1'b1; tick(); gen_done = 1'b0;
    end
  end

  // Monitor / reference model state
  longint win = 0, m_cnt = 0, m_bytes = 0, exp_pps = 0, exp_thr = 0;
  longint gcnt = 0, gap_tgt = 0, cur_gap = 0;
  bit     chk_win = 0, gap_act = 0, prev_arp = 0;

  // Monitor: sampled on the falling edge, i.e. the values the DUT sees next.
  always @(negedge clk) begin
    if (!rst_n) begin
      win = 0; m_cnt = 0; m_bytes = 0;
      chk_win = 0; gap_act = 0; prev_arp = 0;
    end else begin
      if (chk_win) begin
        chk("tx_pps", tx_pps, exp_pps);
        chk("tx_throughput", tx_throughput, exp_thr);
        chk_win = 0;
      end
      if (arp_ack || prev_arp) chk("arp_ack", arp_ack, prev_arp);
      prev_arp = 0;
      if (gap_act) begin
        if (busy) gcnt++;
        else begin
          chk("gap_cycles", gcnt, gap_tgt);
          gap_act = 0;
        end
      end
      if (gen_done && busy && cur_gap != 0) begin
        gap_act = 1; gcnt = 0; gap_tgt = cur_gap;
      end
      if (gen_req) begin
        if (sb.size() == 0) chk("unexpected_req", gen_req, 0);
        else begin
          chk("gen_kind", gen_kind, sb[0].kind);
          chk("gen_len", gen_len, sb[0].len);
          if (gen_ack) begin
            cur_gap = sb[0].gap;
            void'(sb.pop_front());
            n_acc++;
            if (gen_kind) prev_arp = 1;
          end
        end
        if (gen_ack && !gen_kind) begin
          m_cnt++;
          m_bytes += gen_len;
          if (m_bytes > 64'hFFFF_FFFF) m_bytes = 64'hFFFF_FFFF;
        end
      end
      if (win == CLK_HZ - 1) begin
        exp_pps = m_cnt; exp_thr = m_bytes;
        m_cnt = 0; m_bytes = 0; chk_win = 1;
        win = 0;
      end else win++;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic wait_req();
    for (int i = 0; i < 200 && !gen_req; i++) tick();
    chk("req_seen", gen_req, 1);
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 500 && n_acc < target; i++) tick();
    chk("accept_count", n_acc, target);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 1000 && (sb.size() != 0 || busy); i++) tick();
    chk("drained", sb.size(), 0);
    chk("idle_busy", busy, 0);
  endtask

  task automatic test_frame(input int len, input longint ifg, input int ad, input int dd);
    ack_dly = ad; done_dly = dd;
    frame_len = 16'(len); inter_frame_gap = 32'(ifg);
    sb.push_back('{kind: 1'b0, len: clamp_len(len), gap: gap_of(ifg)});
    tx_enable = 1'b1;
    wait_req();
    tx_enable = 1'b0;   // falling in REQ must not withdraw the request
    wait_drain();
  endtask

  task automatic arp_frame(input int edges, input longint ifg, input int dd);
    ack_dly = 8; done_dly = dd;
    tx_enable = 1'b0; inter_frame_gap = 32'(ifg);
    sb.push_back('{kind: 1'b1, len: 64, gap: gap_of(ifg)});
    for (int e = 0; e < edges; e++) begin
      req_arp = 1'b1; tick(); req_arp = 1'b0; tick();
    end
    wait_drain();
  endtask

  initial begin
    int start, len, k;
    longint ifg;

    // Reset with req_arp already high: that level is not an edge.
    req_arp = 1'b1;
    repeat (3) tick();
    chk("rst_gen_req", gen_req, 0);
    chk("rst_gen_kind", gen_kind, 0);
    chk("rst_gen_len", gen_len, 0);
    chk("rst_arp_ack", arp_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_pps", tx_pps, 0);
    chk("rst_tx_throughput", tx_throughput, 0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("no_arp_from_level", busy, 0);
    req_arp = 1'b0;
    tick();

    // Directed clamp / gap corners
    test_frame(20, 12, 0, 3);
    test_frame(2000, 12, 1, 5);
    test_frame(100, 0, 0, 1);
    test_frame(1518, 9, 2, 2);

    // ARP while idle: three merged edges give one frame
    arp_frame(3, 16, 4);
    repeat (5) tick();
    chk("arp_idle_busy", busy, 0);

    // ARP priority over running test traffic
    ack_dly = 0; done_dly = 6;
    frame_len = 16'd256; inter_frame_gap = 32'd20;
    sb.push_back('{kind: 1'b0, len: 256, gap: 3});
    sb.push_back('{kind: 1'b1, len: 64,  gap: 3});
    sb.push_back('{kind: 1'b0, len: 256, gap: 3});
    start = n_acc;
    tx_enable = 1'b1;
    wait_acc(start + 1);
    req_arp = 1'b1; tick(); req_arp = 1'b0;
    for (int i = 0; i < 200 && !(n_acc >= start + 2 && gen_req); i++) tick();
    chk("third_req_seen", gen_req, 1);
    tx_enable = 1'b0;
    wait_drain();

    // Backpressure: ack held off 50 cycles, enable dropped meanwhile
    ack_dly = 50; done_dly = 5;
    frame_len = 16'd300; inter_frame_gap = 32'd20;
    sb.push_back('{kind: 1'b0, len: 300, gap: 3});
    tx_enable = 1'b1;
    wait_req();
    repeat (10) tick();
    tx_enable = 1'b0;
    wait_drain();
    repeat (5) tick();
    chk("bp_no_more_req", gen_req, 0);

    // Randomised mix
    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(0, 6);
      case (k)
        0: len = 20;
        1: len = 2000;
        2: len = 63;
        3: len = 1519;
        default: len = $urandom_range(0, 3000);
      endcase
      ifg = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
      if ($urandom_range(0, 3) == 0) arp_frame($urandom_range(1, 3), ifg, $urandom_range(1, 8));
      else test_frame(len, ifg, $urandom_range(0, 4), $urandom_range(1, 10));
    end

    // Maximum gap: must not wrap to a tiny value
    ack_dly = 0; done_dly = 3;
    frame_len = 16'd100; inter_frame_gap = 32'hFFFF_FFFF;
    sb.push_back('{kind: 1'b0, len: 100, gap: 0});
    tx_enable = 1'b1;
    wait_req();
    tx_enable = 1'b0;
    repeat (2000) tick();
    chk("huge_gap_still_busy", busy, 1);
    do_reset();
    chk("huge_rst_busy", busy, 0);

    // Steady traffic: 12-cycle period, 100 frames per 1200-cycle window
    do_reset();
    ack_dly = 0; done_dly = 8;
    frame_len = 16'd64; inter_frame_gap = 32'd12;
    tx_enable = 1'b1;
    for (int i = 0; i < 2400; i++) begin
      while (sb.size() < 2) sb.push_back('{kind: 1'b0, len: 64, gap: 2});
      tick();
    end
    chk("steady_tx_pps", tx_pps, 100);
    chk("steady_tx_throughput", tx_throughput, 6400);
    tx_enable = 1'b0;
    repeat (30) tick();
    sb.delete();

    // Reset while in WAIT; the late gen_done must be ignored
    ack_dly = 0; done_dly = 10;
    frame_len = 16'd200; inter_frame_gap = 32'd8;
    sb.push_back('{kind: 1'b0, len: 200, gap: 1});
    start = n_acc;
    tx_enable = 1'b1;
    wait_acc(start + 1);
    tx_enable = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("midrst_gen_req", gen_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tx_pps", tx_pps, 0);
    chk("midrst_tx_throughput", tx_throughput, 0);
    repeat (15) tick();
    chk("late_done_busy", busy, 0);
    chk("late_done_req", gen_req, 0);
    chk("final_queue", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
